// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU select codes and the decoded ALU packet type
// used by the issue stage and its decoder.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0011;
    localparam logic [3:0] SEL_SLL = 4'b0110;
    localparam logic [3:0] SEL_SHR = 4'b0100;
    localparam logic [3:0] SEL_XOR = 4'b1100;
    localparam logic [3:0] SEL_OR  = 4'b0100;
    localparam logic [3:0] SEL_AND = 4'b1000;

    localparam logic [1:0] CMP_NONE = 2'b00;
    localparam logic [1:0] CMP_SLT  = 2'b01;
    localparam logic [1:0] CMP_SLTU = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [3:0]  alu_sel;
        logic        alu_arith;
        logic        alu_cin;
        logic [1:0]  cmp_kind;
        logic [4:0]  rd;
        logic        illegal;
    } alu_pkt_t;

    localparam int PKT_W = $bits(alu_pkt_t);

    localparam alu_pkt_t ILLEGAL_PKT = '{
        alu_a: 32'd0, alu_b: 32'd0, alu_sel: SEL_ADD, alu_arith: 1'b1,
        alu_cin: 1'b0, cmp_kind: CMP_NONE, rd: 5'd0, illegal: 1'b1
    };

    // OP and OP-IMM share the funct3 mapping; alt selects SUB/SRA.
    function automatic alu_pkt_t apply_funct3(alu_pkt_t p, logic [2:0] f3, logic alt);
        alu_pkt_t r;
        r = p;
        case (f3)
            F3_ADD_SUB: r.alu_sel = alt ? SEL_SUB : SEL_ADD;
            F3_SLL:     r.alu_sel = SEL_SLL;
            F3_SLT: begin
                r.alu_sel  = SEL_SUB;
                r.cmp_kind = CMP_SLT;
            end
            F3_SLTU: begin
                r.alu_sel  = SEL_SUB;
                r.cmp_kind = CMP_SLTU;
            end
            F3_XOR: begin
                r.alu_sel   = SEL_XOR;
                r.alu_arith = 1'b0;
            end
            F3_SRL_SRA: begin
                r.alu_sel = SEL_SHR;
                r.alu_cin = alt;
            end
            F3_OR: begin
                r.alu_sel   = SEL_OR;
                r.alu_arith = 1'b0;
            end
            default: begin
                r.alu_sel   = SEL_AND;
                r.alu_arith = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Purely combinational RV32I integer-ALU decoder: turns an instruction and its
// operands into one ALU packet, collapsing unsupported encodings to a safe bubble.
module alu_decode
    import rv32i_pkg::*;
(
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    output logic [PKT_W-1:0] pkt
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] shamt_b;
    logic [31:0] upper_b;
    logic        legal;
    alu_pkt_t    d;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign shamt_b = {27'd0, instr[24:20]};
    assign upper_b = {instr[31:12], 12'd0};

    // Start from an ADD of the register operands and refine per opcode.
    always_comb begin
        d           = '0;
        d.alu_arith = 1'b1;
        d.rd        = instr[11:7];
        d.alu_a     = rs1_val;
        d.alu_b     = rs2_val;
        legal       = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
                d = apply_funct3(d, funct3, funct7 == F7_ALT);
            end
            OPC_OP_IMM: begin
                legal   = 1'b1;
                d.alu_b = imm_i;
                if (funct3 == F3_SLL) begin
                    legal   = (funct7 == F7_BASE);
                    d.alu_b = shamt_b;
                end else if (funct3 == F3_SRL_SRA) begin
                    legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    d.alu_b = shamt_b;
                end
                d = apply_funct3(d, funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
            end
            OPC_LUI: begin
                legal   = 1'b1;
                d.alu_a = 32'd0;
                d.alu_b = upper_b;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                d.alu_a = pc;
                d.alu_b = upper_b;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            d = ILLEGAL_PKT;
        end
    end

    assign pkt = d;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes at acceptance and buffers packets in an output
// register plus one skid entry so in_ready can be fully registered.
module alu_issue
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    output logic        alu_arith,
    output logic        alu_cin,
    output logic [1:0]  cmp_kind,
    output logic [4:0]  rd,
    output logic        illegal
);

    issue_state_t     state;
    issue_state_t     state_nxt;
    logic [PKT_W-1:0] dec_bits;
    alu_pkt_t         dec_pkt;
    alu_pkt_t         out_pkt;
    alu_pkt_t         skid_pkt;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_out_dec;
    logic             load_out_skid;
    logic             load_skid;

    alu_decode u_decode (
        .instr   (instr),
        .pc      (pc),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .pkt     (dec_bits)
    );

    assign dec_pkt   = dec_bits;
    assign out_valid = (state != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // in_ready is registered from the next state so it never waits on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_FULL);
        end
    end

    always_comb begin
        state_nxt     = state;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = ST_ONE;
                    load_out_dec = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_dec = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_nxt     = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pkt  <= '0;
            skid_pkt <= '0;
        end else begin
            if (load_out_dec) begin
                out_pkt <= dec_pkt;
            end else if (load_out_skid) begin
                out_pkt <= skid_pkt;
            end
            if (load_skid) begin
                skid_pkt <= dec_pkt;
            end
        end
    end

    assign alu_a     = out_pkt.alu_a;
    assign alu_b     = out_pkt.alu_b;
    assign alu_sel   = out_pkt.alu_sel;
    assign alu_arith = out_pkt.alu_arith;
    assign alu_cin   = out_pkt.alu_cin;
    assign cmp_kind  = out_pkt.cmp_kind;
    assign rd        = out_pkt.rd;
    assign illegal   = out_pkt.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: decode vector table, backpressure and
// reset-in-FULL sequences, and random traffic checked through a scoreboard.
module tb_alu_issue;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic        alu_arith;
    logic        alu_cin;
    logic [1:0]  cmp_kind;
    logic [4:0]  rd;
    logic        illegal;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] p;
        logic [31:0] r1;
        logic [31:0] r2;
        alu_pkt_t    exp;
    } vec_t;

    vec_t     vecs[$];
    alu_pkt_t sb_q[$];
    alu_pkt_t drv_exp;
    alu_pkt_t got_pkt;
    alu_pkt_t mon_exp;
    alu_pkt_t ill;
    int       errors;
    int       checks;
    int       pkt_idx;
    logic     stress_on;
    int       imm_rows[9] = '{0, 3, 4, 5, 8, 9, 2, 6, 7};

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_arith (alu_arith),
        .alu_cin   (alu_cin),
        .cmp_kind  (cmp_kind),
        .rd        (rd),
        .illegal   (illegal)
    );

    assign got_pkt = {alu_a, alu_b, alu_sel, alu_arith, alu_cin, cmp_kind, rd, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic alu_pkt_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] sel,
                                    logic ar, logic ci, logic [1:0] cm, logic [4:0] d, logic il);
        alu_pkt_t r;
        r = '{a, b, sel, ar, ci, cm, d, il};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input alu_pkt_t e);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1_val  = a;
        rs2_val  = b;
        drv_exp  = e;
    endtask

    // Offer one instruction and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                                 input logic [31:0] b, input alu_pkt_t e);
        logic acc;
        int   n;
        drive(i, p, a, b, e);
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) failNow("accept_timeout");
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) failNow("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic r_row(input int row, output logic [6:0] f7, output logic [2:0] f3,
                         output logic [3:0] sel, output logic ar, output logic ci, output logic [1:0] cm);
        ar = 1'b1; ci = 1'b0; cm = 2'b00; f7 = 7'b0000000;
        case (row)
            0: begin f3 = 3'b000; sel = 4'b0000; end
            1: begin f3 = 3'b000; sel = 4'b0011; f7 = 7'b0100000; end
            2: begin f3 = 3'b001; sel = 4'b0110; end
            3: begin f3 = 3'b010; sel = 4'b0011; cm = 2'b01; end
            4: begin f3 = 3'b011; sel = 4'b0011; cm = 2'b10; end
            5: begin f3 = 3'b100; sel = 4'b1100; ar = 1'b0; end
            6: begin f3 = 3'b101; sel = 4'b0100; end
            7: begin f3 = 3'b101; sel = 4'b0100; ci = 1'b1; f7 = 7'b0100000; end
            8: begin f3 = 3'b110; sel = 4'b0100; ar = 1'b0; end
            default: begin f3 = 3'b111; sel = 4'b1000; ar = 1'b0; end
        endcase
    endtask

    // Build a random legal instruction together with its expected packet.
    task automatic gen_random(output logic [31:0] ins, output logic [31:0] p, output logic [31:0] a,
                              output logic [31:0] b, output alu_pkt_t e);
        int k, row;
        logic [4:0] rdf, rs1f, rs2f;
        logic [11:0] imm;
        logic [19:0] up;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] sel;
        logic ar, ci;
        logic [1:0] cm;
        k    = $urandom_range(0, 20);
        rdf  = 5'($urandom_range(0, 31));
        rs1f = 5'($urandom_range(0, 31));
        rs2f = 5'($urandom_range(0, 31));
        imm  = 12'($urandom_range(0, 4095));
        up   = 20'($urandom_range(0, 1048575));
        p    = $urandom;
        a    = $urandom;
        b    = $urandom;
        row  = (k < 10) ? k : ((k < 19) ? imm_rows[k - 10] : 0);
        r_row(row, f7, f3, sel, ar, ci, cm);
        if (k < 10) begin
            ins = {f7, rs2f, rs1f, f3, rdf, 7'b0110011};
            e   = mk(a, b, sel, ar, ci, cm, rdf, 1'b0);
        end else if (k < 19) begin
            if (row == 2 || row == 6 || row == 7) begin
                ins = {f7, rs2f, rs1f, f3, rdf, 7'b0010011};
                e   = mk(a, {27'd0, rs2f}, sel, ar, ci, cm, rdf, 1'b0);
            end else begin
                ins = {imm, rs1f, f3, rdf, 7'b0010011};
                e   = mk(a, {{20{imm[11]}}, imm}, sel, ar, ci, cm, rdf, 1'b0);
            end
        end else if (k == 19) begin
            ins = {up, rdf, 7'b0110111};
            e   = mk(32'd0, {up, 12'd0}, 4'b0000, 1'b1, 1'b0, 2'b00, rdf, 1'b0);
        end else begin
            ins = {up, rdf, 7'b0010111};
            e   = mk(p, {up, 12'd0}, 4'b0000, 1'b1, 1'b0, 2'b00, rdf, 1'b0);
        end
    endtask

    task automatic add_vec(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] b, input alu_pkt_t e);
        vec_t v;
        v.ins = i; v.p = p; v.r1 = a; v.r2 = b; v.exp = e;
        vecs.push_back(v);
    endtask

    // Scoreboard: record on input handshake, compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    failNow("unexpected_packet");
                end else begin
                    mon_exp = sb_q.pop_front();
                    checkOutput($sformatf("pkt%0d", pkt_idx), 96'(got_pkt), 96'(mon_exp));
                    pkt_idx++;
                end
            end
            if (in_valid && in_ready) sb_q.push_back(drv_exp);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stress_on) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [31:0] ri, rp, ra, rb;
        alu_pkt_t re;
        alu_pkt_t p1, p2, p3, p4, p5, p6;
        errors = 0; checks = 0; pkt_idx = 0; stress_on = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1_val = '0; rs2_val = '0; drv_exp = '0;
        ill = mk(32'd0, 32'd0, 4'b0000, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1);

        add_vec(32'hFFF08293, 32'h1000, 32'h10, 32'h3, mk(32'h10, 32'hFFFFFFFF, 4'b0000, 1, 0, 2'b00, 5'd5, 0));
        add_vec(32'h40415193, 32'h1000, 32'h80000000, 32'h3, mk(32'h80000000, 32'h4, 4'b0100, 1, 1, 2'b00, 5'd3, 0));
        add_vec(32'h42415193, 32'h1000, 32'h80000000, 32'h3, ill);
        add_vec(32'h123453B7, 32'h1000, 32'h5, 32'h6, mk(32'h0, 32'h12345000, 4'b0000, 1, 0, 2'b00, 5'd7, 0));
        add_vec(32'h0000006F, 32'h1000, 32'h5, 32'h6, ill);
        add_vec(32'h40C58533, 32'h1000, 32'h55, 32'h22, mk(32'h55, 32'h22, 4'b0011, 1, 0, 2'b00, 5'd10, 0));
        add_vec(32'h003120B3, 32'h1000, 32'hFFFFFFFE, 32'h1, mk(32'hFFFFFFFE, 32'h1, 4'b0011, 1, 0, 2'b01, 5'd1, 0));
        add_vec(32'h0062C233, 32'h1000, 32'hF0F0, 32'hFF00, mk(32'hF0F0, 32'hFF00, 4'b1100, 0, 0, 2'b00, 5'd4, 0));
        add_vec(32'h0062E233, 32'h1000, 32'hF0F0, 32'hFF00, mk(32'hF0F0, 32'hFF00, 4'b0100, 0, 0, 2'b00, 5'd4, 0));
        add_vec(32'h0062F233, 32'h1000, 32'hF0F0, 32'hFF00, mk(32'hF0F0, 32'hFF00, 4'b1000, 0, 0, 2'b00, 5'd4, 0));
        add_vec(32'h00629233, 32'h1000, 32'h1, 32'h1F, mk(32'h1, 32'h1F, 4'b0110, 1, 0, 2'b00, 5'd4, 0));
        add_vec(32'h0062D233, 32'h1000, 32'h1, 32'h1F, mk(32'h1, 32'h1F, 4'b0100, 1, 0, 2'b00, 5'd4, 0));
        add_vec(32'hABCDE497, 32'h2000, 32'h7, 32'h8, mk(32'h2000, 32'hABCDE000, 4'b0000, 1, 0, 2'b00, 5'd9, 0));
        add_vec(32'h40311293, 32'h1000, 32'h7, 32'h8, ill);
        add_vec(32'h403112B3, 32'h1000, 32'h7, 32'h8, ill);
        add_vec(32'h023102B3, 32'h1000, 32'h7, 32'h8, ill);
        add_vec(32'h7FF4F413, 32'h1000, 32'h12345678, 32'h8, mk(32'h12345678, 32'h7FF, 4'b1000, 0, 0, 2'b00, 5'd8, 0));
        add_vec(32'h8001B113, 32'h1000, 32'h9, 32'h8, mk(32'h9, 32'hFFFFF800, 4'b0011, 1, 0, 2'b10, 5'd2, 0));
        add_vec(32'h02415193, 32'h1000, 32'h9, 32'h8, ill);
        add_vec(32'h00012083, 32'h1000, 32'h9, 32'h8, ill);

        #12;
        checkOutput("reset_out_valid", 96'(out_valid), 96'd0);
        checkOutput("reset_in_ready", 96'(in_ready), 96'd1);
        checkOutput("reset_data", 96'(got_pkt), 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] decode vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ins, vecs[i].p, vecs[i].r1, vecs[i].r2, vecs[i].exp);
            checkOutput($sformatf("latency%0d", i), 96'(out_valid), 96'd1);
        end
        waitDrain();
        checkOutput("drained_empty", 96'(out_valid), 96'd0);

        $display("[TB] backpressure sequence");
        p1 = mk(32'h11, 32'h1, 4'b0000, 1, 0, 2'b00, 5'd1, 0);
        p2 = mk(32'h22, 32'h2, 4'b0000, 1, 0, 2'b00, 5'd2, 0);
        p3 = mk(32'h33, 32'h3, 4'b0000, 1, 0, 2'b00, 5'd3, 0);
        out_ready = 1'b0;
        drive(32'h002080B3, 32'h0, 32'h11, 32'h1, p1);
        @(posedge clk); #1;
        drive(32'h00208133, 32'h0, 32'h22, 32'h2, p2);
        @(posedge clk); #1;
        checkOutput("bp_in_ready_full", 96'(in_ready), 96'd0);
        checkOutput("bp_head", 96'(got_pkt), 96'(p1));
        drive(32'h002081B3, 32'h0, 32'h33, 32'h3, p3);
        @(posedge clk); #1;
        checkOutput("bp_held_in_ready", 96'(in_ready), 96'd0);
        checkOutput("bp_head_stable", 96'(got_pkt), 96'(p1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_second", 96'(got_pkt), 96'(p2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_third", 96'(got_pkt), 96'(p3));
        checkOutput("bp_third_valid", 96'(out_valid), 96'd1);
        @(posedge clk); #1;
        checkOutput("bp_done", 96'(out_valid), 96'd0);

        $display("[TB] reset while full");
        p4 = mk(32'h44, 32'h4, 4'b0000, 1, 0, 2'b00, 5'd4, 0);
        p5 = mk(32'h55, 32'h5, 4'b0000, 1, 0, 2'b00, 5'd5, 0);
        p6 = mk(32'h66, 32'h6, 4'b0000, 1, 0, 2'b00, 5'd6, 0);
        out_ready = 1'b0;
        drive(32'h00208233, 32'h0, 32'h44, 32'h4, p4);
        @(posedge clk); #1;
        drive(32'h002082B3, 32'h0, 32'h55, 32'h5, p5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("rst_pre_full", 96'(in_ready), 96'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 96'(out_valid), 96'd0);
        checkOutput("rst_in_ready", 96'(in_ready), 96'd1);
        checkOutput("rst_data", 96'(got_pkt), 96'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_no_stale", 96'(out_valid), 96'd0);
        applyStimulus(32'h00208333, 32'h0, 32'h66, 32'h6, p6);
        waitDrain();

        $display("[TB] random stream with ready held");
        applyStimulus(32'h003130B3, 32'h0, 32'h5, 32'h9, mk(32'h5, 32'h9, 4'b0011, 1, 0, 2'b10, 5'd1, 0));
        for (int i = 0; i < 99; i++) begin
            gen_random(ri, rp, ra, rb, re);
            applyStimulus(ri, rp, ra, rb, re);
        end
        waitDrain();

        $display("[TB] random stream with random ready");
        stress_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            gen_random(ri, rp, ra, rb, re);
            applyStimulus(ri, rp, ra, rb, re);
        end
        stress_on = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        waitDrain();
        checkOutput("final_empty", 96'(out_valid), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
